// File: rtl/conv_pass_sequencer_pkg.sv
// Shared types and helpers for the conv pass sequencer: FSM encoding,
// size decodes and the beat-count width.
package conv_pass_sequencer_pkg;

  localparam int unsigned BEAT_CNT_W = 21;
  localparam int unsigned TMR_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_LOAD_K,
    ST_SETTLE,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_NEXT,
    ST_FIN
  } state_e;

  // Image side S for codes 0..4; invalid codes decode to zero.
  function automatic logic [BEAT_CNT_W-1:0] decode_s(input logic [2:0] code);
    case (code)
      3'd0:    decode_s = BEAT_CNT_W'(4);
      3'd1:    decode_s = BEAT_CNT_W'(8);
      3'd2:    decode_s = BEAT_CNT_W'(16);
      3'd3:    decode_s = BEAT_CNT_W'(32);
      3'd4:    decode_s = BEAT_CNT_W'(64);
      default: decode_s = '0;
    endcase
  endfunction

  function automatic logic [BEAT_CNT_W-1:0] decode_c(input logic [1:0] code);
    case (code)
      2'd0:    decode_c = BEAT_CNT_W'(256);
      2'd1:    decode_c = BEAT_CNT_W'(128);
      2'd2:    decode_c = BEAT_CNT_W'(64);
      default: decode_c = BEAT_CNT_W'(32);
    endcase
  endfunction

  function automatic logic img_code_valid(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

  // Kernel beats (C) followed by image beats (S*S*C); max 1048832 fits in 21 bits.
  function automatic logic [BEAT_CNT_W-1:0] beats_per_pass(input logic [2:0] img_code,
                                                           input logic [1:0] ch_code);
    logic [BEAT_CNT_W-1:0] s;
    logic [BEAT_CNT_W-1:0] c;
    s = decode_s(img_code);
    c = decode_c(ch_code);
    return c + (s * s * c);
  endfunction

endpackage

// File: rtl/conv_beat_counter.sv
// Per-pass beat counter: cleared on load, advanced per accepted beat,
// flags the terminal (last) beat of the pass.
module conv_beat_counter
  import conv_pass_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = BEAT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_aresetn,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_beats,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == (i_beats - WIDTH'(1)));

endmodule

// File: rtl/conv_pass_sequencer.sv
// Sequences one conv layer run: core reset, then per output channel a kernel
// load, settle gap, gated stream pass and wait for the core's done pulse.
module conv_pass_sequencer
  import conv_pass_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned SETTLE_CYCLES  = 10,   // must be >= 1
  parameter int unsigned BEAT_CNT_WIDTH = BEAT_CNT_W
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [2:0]            image_size_choose,
  input  logic [1:0]            channel_size_choose,
  input  logic [8:0]            num_out_ch,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  conv_rst_n,
  output logic                  load_kernel_bram,
  input  logic                  conv_done,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error,
  output logic [7:0]            out_ch_idx
);

  state_e                    r_state;
  logic [TMR_W-1:0]          r_timer;
  logic [2:0]                r_img_code;
  logic [1:0]                r_ch_code;
  logic [8:0]                r_num_out_ch;

  logic [BEAT_CNT_WIDTH-1:0] w_beats;
  logic                      w_in_stream;
  logic                      w_hs;
  logic                      w_tc;
  logic                      w_cfg_ok;
  logic [8:0]                w_next_idx;

  assign w_beats     = BEAT_CNT_WIDTH'(beats_per_pass(r_img_code, r_ch_code));
  assign w_in_stream = (r_state == ST_STREAM);
  assign w_cfg_ok    = (num_out_ch != 9'd0) && img_code_valid(image_size_choose);
  assign w_next_idx  = {1'b0, out_ch_idx} + 9'd1;

  // Stream is a straight pass-through, gated so nothing moves outside STREAM.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = w_in_stream & s_axis_tvalid;
  assign s_axis_tready = w_in_stream & m_axis_tready;
  assign w_hs          = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = w_in_stream & w_tc;

  conv_beat_counter #(
    .WIDTH(BEAT_CNT_WIDTH)
  ) u_beat_counter (
    .i_clk    (clk),
    .i_aresetn(aresetn),
    .i_load   (r_state == ST_LOAD_K),
    .i_inc    (w_hs),
    .i_beats  (w_beats),
    .o_tc     (w_tc)
  );

  // Run FSM with registered control outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state          <= ST_IDLE;
      r_timer          <= '0;
      r_img_code       <= '0;
      r_ch_code        <= '0;
      r_num_out_ch     <= '0;
      conv_rst_n       <= 1'b0;
      load_kernel_bram <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_error        <= 1'b0;
      out_ch_idx       <= '0;
    end else begin
      load_kernel_bram <= 1'b0;
      done             <= 1'b0;
      cfg_error        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          conv_rst_n <= 1'b1;
          if (start) begin
            if (w_cfg_ok) begin
              r_img_code   <= image_size_choose;
              r_ch_code    <= channel_size_choose;
              r_num_out_ch <= num_out_ch;
              out_ch_idx   <= '0;
              r_timer      <= '0;
              conv_rst_n   <= 1'b0;
              busy         <= 1'b1;
              r_state      <= ST_CORE_RST;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        ST_CORE_RST: begin
          if (r_timer == TMR_W'(1)) begin
            conv_rst_n       <= 1'b1;
            load_kernel_bram <= 1'b1;
            r_state          <= ST_LOAD_K;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_LOAD_K: begin
          r_timer <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_timer == TMR_W'(SETTLE_CYCLES - 1)) begin
            r_state <= ST_STREAM;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_STREAM: begin
          if (w_hs && w_tc) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (conv_done) begin
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          out_ch_idx <= out_ch_idx + 8'd1;
          if (w_next_idx < r_num_out_ch) begin
            load_kernel_bram <= 1'b1;
            r_state          <= ST_LOAD_K;
          end else begin
            done    <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Directed self-checking bench for conv_pass_sequencer: single and multi-pass
// runs, random stalls, config rejection, mid-stream reset and ignored inputs.
module tb_conv_pass_sequencer;

  localparam int unsigned DW     = 32;
  localparam int unsigned SETTLE = 10;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    image_size_choose = 3'd0;
  logic [1:0]    channel_size_choose = 2'd0;
  logic [8:0]    num_out_ch = 9'd0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          conv_rst_n;
  logic          load_kernel_bram;
  logic          conv_done = 1'b0;
  logic          busy;
  logic          done;
  logic          cfg_error;
  logic [7:0]    out_ch_idx;

  conv_pass_sequencer #(
    .DATA_WIDTH(DW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start),
    .image_size_choose(image_size_choose), .channel_size_choose(channel_size_choose),
    .num_out_ch(num_out_ch),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .conv_rst_n(conv_rst_n), .load_kernel_bram(load_kernel_bram), .conv_done(conv_done),
    .busy(busy), .done(done), .cfg_error(cfg_error), .out_ch_idx(out_ch_idx)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Scenario controls (written by the test sequence only).
  bit          rand_mode = 1'b0;
  int unsigned done_delay = 3;
  int unsigned beats_exp = 0;
  bit          clr_req = 1'b0;
  bit          done_req = 1'b0;

  // Monitor statistics (written by the monitor only).
  bit          clr_ack = 1'b0;
  int unsigned cyc = 0;
  int unsigned hs_cnt = 0, tlast_cnt = 0, tlast_total = 0, tlast_at = 0, tlast_err = 0;
  int unsigned data_err = 0, load_cnt = 0, done_cnt = 0, cfg_cnt = 0, busy_cnt = 0;
  int unsigned rst_low_cnt = 0, load_cyc = 0, first_hs_cyc = 0;
  logic [7:0]  load_idx [0:3];

  // Driver-private state.
  bit          done_ack = 1'b0;
  int unsigned drv_tlast_seen = 0;
  int unsigned done_cd = 0;

  function automatic logic [DW-1:0] pat(input int unsigned n);
    return DW'(n * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Upstream source, downstream sink readiness and conv-core done responder.
  always @(posedge clk) begin
    #1;
    s_axis_tdata = pat(hs_cnt);
    if (rand_mode) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
    end else begin
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
    end
    conv_done = 1'b0;
    if (tlast_total != drv_tlast_seen) begin
      drv_tlast_seen = tlast_total;
      done_cd = done_delay;
    end else if (done_cd != 0) begin
      done_cd = done_cd - 1;
      if (done_cd == 0) conv_done = 1'b1;
    end
    if (done_req != done_ack) begin
      done_ack = done_req;
      conv_done = 1'b1;
    end
  end

  // Sample everything mid-cycle; a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      hs_cnt = 0; tlast_cnt = 0; tlast_at = 0; tlast_err = 0; data_err = 0;
      load_cnt = 0; done_cnt = 0; cfg_cnt = 0; busy_cnt = 0; rst_low_cnt = 0;
      load_cyc = 0; first_hs_cyc = 0;
      for (int i = 0; i < 4; i++) load_idx[i] = 8'hFF;
    end else begin
      if (load_kernel_bram) begin
        if (load_cnt < 4) load_idx[load_cnt] = out_ch_idx;
        load_cnt = load_cnt + 1;
        load_cyc = cyc;
      end
      if (done) done_cnt = done_cnt + 1;
      if (cfg_error) cfg_cnt = cfg_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (busy && !conv_rst_n) rst_low_cnt = rst_low_cnt + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (hs_cnt == 0) first_hs_cyc = cyc;
        if (m_axis_tdata !== pat(hs_cnt)) data_err = data_err + 1;
        hs_cnt = hs_cnt + 1;
        if (m_axis_tlast) begin
          tlast_cnt = tlast_cnt + 1;
          tlast_total = tlast_total + 1;
          tlast_at = hs_cnt;
          if (beats_exp == 0 || (hs_cnt % beats_exp) != 0) tlast_err = tlast_err + 1;
        end
      end
    end
  end

  task automatic clear_stats();
    clr_req = ~clr_req;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [2:0] img, input logic [1:0] ch, input logic [8:0] num);
    @(posedge clk); #1;
    image_size_choose = img; channel_size_choose = ch; num_out_ch = num; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    image_size_choose = 3'd7; channel_size_choose = 2'd3; num_out_ch = 9'd0;
  endtask

  task automatic wait_done(input int unsigned budget, input string tag);
    int unsigned n = 0;
    int unsigned d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done_cnt == d0) begin
      n_bad++;
      $display("FAIL %s_timeout: no done pulse within %0d cycles", tag, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({conv_rst_n, load_kernel_bram, m_axis_tvalid, m_axis_tlast, s_axis_tready,
         busy, done, cfg_error} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {conv_rst_n, load_kernel_bram, m_axis_tvalid, m_axis_tlast, s_axis_tready,
                busy, done, cfg_error});
    end
    n_cmp++;
    if (out_ch_idx !== 8'd0) begin
      n_bad++; $display("FAIL reset_idx: got %0d expected 0", out_ch_idx);
    end
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (conv_rst_n !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: conv_rst_n=%b busy=%b expected 1/0", conv_rst_n, busy);
    end
  endtask

  task automatic test_single_pass();
    clear_stats();
    beats_exp = 4352; done_delay = 3; rand_mode = 1'b0;
    do_start(3'd0, 2'd0, 9'd1);
    wait_done(10000, "single");
    n_cmp++; if (hs_cnt !== 4352) begin n_bad++; $display("FAIL single_beats: got %0d expected 4352", hs_cnt); end
    n_cmp++; if (tlast_cnt !== 1 || tlast_at !== 4352) begin n_bad++; $display("FAIL single_tlast: count %0d at %0d expected 1 at 4352", tlast_cnt, tlast_at); end
    n_cmp++; if (load_cnt !== 1) begin n_bad++; $display("FAIL single_loads: got %0d expected 1", load_cnt); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
    n_cmp++; if (data_err !== 0) begin n_bad++; $display("FAIL single_data: got %0d bad beats expected 0", data_err); end
    n_cmp++; if (rst_low_cnt !== 2) begin n_bad++; $display("FAIL single_core_rst: got %0d cycles expected 2", rst_low_cnt); end
    n_cmp++; if (first_hs_cyc - load_cyc !== SETTLE + 1) begin n_bad++; $display("FAIL single_settle: got %0d expected %0d", first_hs_cyc - load_cyc, SETTLE + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_multi_pass();
    clear_stats();
    beats_exp = 544; done_delay = 20; rand_mode = 1'b0;
    do_start(3'd0, 2'd3, 9'd3);
    wait_done(10000, "multi");
    n_cmp++; if (hs_cnt !== 1632) begin n_bad++; $display("FAIL multi_beats: got %0d expected 1632", hs_cnt); end
    n_cmp++; if (tlast_cnt !== 3 || tlast_err !== 0) begin n_bad++; $display("FAIL multi_tlast: count %0d misplaced %0d expected 3/0", tlast_cnt, tlast_err); end
    n_cmp++; if (load_cnt !== 3) begin n_bad++; $display("FAIL multi_loads: got %0d expected 3", load_cnt); end
    n_cmp++;
    if ({load_idx[0], load_idx[1], load_idx[2]} !== {8'd0, 8'd1, 8'd2}) begin
      n_bad++;
      $display("FAIL multi_idx: got %0d,%0d,%0d expected 0,1,2", load_idx[0], load_idx[1], load_idx[2]);
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL multi_done: got %0d expected 1", done_cnt); end
    n_cmp++; if (out_ch_idx !== 8'd3) begin n_bad++; $display("FAIL multi_idx_hold: got %0d expected 3", out_ch_idx); end
    n_cmp++; if (data_err !== 0) begin n_bad++; $display("FAIL multi_data: got %0d bad beats expected 0", data_err); end
  endtask

  task automatic test_random_stall();
    clear_stats();
    beats_exp = 4160; done_delay = 3; rand_mode = 1'b1;
    do_start(3'd1, 2'd2, 9'd1);
    wait_done(40000, "stall");
    rand_mode = 1'b0;
    n_cmp++; if (hs_cnt !== 4160) begin n_bad++; $display("FAIL stall_beats: got %0d expected 4160", hs_cnt); end
    n_cmp++; if (tlast_cnt !== 1 || tlast_at !== 4160) begin n_bad++; $display("FAIL stall_tlast: count %0d at %0d expected 1 at 4160", tlast_cnt, tlast_at); end
    n_cmp++; if (data_err !== 0) begin n_bad++; $display("FAIL stall_data: got %0d bad beats expected 0", data_err); end
    n_cmp++; if (load_cnt !== 1 || done_cnt !== 1) begin n_bad++; $display("FAIL stall_pulses: loads %0d dones %0d expected 1/1", load_cnt, done_cnt); end
  endtask

  task automatic test_cfg_error();
    clear_stats();
    do_start(3'd0, 2'd0, 9'd0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cfg_cnt !== 1) begin n_bad++; $display("FAIL cfg_zero_err: got %0d pulses expected 1", cfg_cnt); end
    n_cmp++; if (busy_cnt !== 0 || load_cnt !== 0) begin n_bad++; $display("FAIL cfg_zero_idle: busy %0d loads %0d expected 0/0", busy_cnt, load_cnt); end
    do_start(3'd6, 2'd0, 9'd1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cfg_cnt !== 2) begin n_bad++; $display("FAIL cfg_img_err: got %0d pulses expected 2", cfg_cnt); end
    n_cmp++; if (busy_cnt !== 0 || load_cnt !== 0) begin n_bad++; $display("FAIL cfg_img_idle: busy %0d loads %0d expected 0/0", busy_cnt, load_cnt); end
  endtask

  task automatic test_reset_midstream();
    int unsigned n = 0;
    clear_stats();
    beats_exp = 544; done_delay = 3;
    do_start(3'd0, 2'd3, 9'd1);
    while (hs_cnt < 100 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (hs_cnt !== 100) begin n_bad++; $display("FAIL midrst_reach: got %0d beats expected 100", hs_cnt); end
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({conv_rst_n, load_kernel_bram, m_axis_tvalid, m_axis_tlast, s_axis_tready,
         busy, done, cfg_error} !== 8'b0 || out_ch_idx !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b idx %0d expected 00000000 idx 0",
               {conv_rst_n, load_kernel_bram, m_axis_tvalid, m_axis_tlast, s_axis_tready,
                busy, done, cfg_error}, out_ch_idx);
    end
    repeat (3) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    do_start(3'd0, 2'd3, 9'd1);
    wait_done(5000, "midrst");
    n_cmp++; if (hs_cnt !== 544 || tlast_at !== 544) begin n_bad++; $display("FAIL midrst_rerun: beats %0d tlast at %0d expected 544/544", hs_cnt, tlast_at); end
    n_cmp++; if (data_err !== 0 || tlast_err !== 0) begin n_bad++; $display("FAIL midrst_data: bad beats %0d bad tlast %0d expected 0/0", data_err, tlast_err); end
  endtask

  task automatic test_ignored_inputs();
    int unsigned n = 0;
    clear_stats();
    beats_exp = 544; done_delay = 3;
    do_start(3'd0, 2'd3, 9'd1);
    while (load_cnt == 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    done_req = ~done_req;
    n = 0;
    while (hs_cnt < 50 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    do_start(3'd4, 2'd0, 9'd5);
    wait_done(5000, "ignore");
    n_cmp++; if (hs_cnt !== 544 || tlast_cnt !== 1) begin n_bad++; $display("FAIL ignore_beats: beats %0d tlast %0d expected 544/1", hs_cnt, tlast_cnt); end
    n_cmp++; if (load_cnt !== 1 || done_cnt !== 1) begin n_bad++; $display("FAIL ignore_pulses: loads %0d dones %0d expected 1/1", load_cnt, done_cnt); end
    n_cmp++; if (rst_low_cnt !== 2) begin n_bad++; $display("FAIL ignore_core_rst: got %0d expected 2", rst_low_cnt); end
    n_cmp++; if (first_hs_cyc - load_cyc !== SETTLE + 1) begin n_bad++; $display("FAIL ignore_settle: got %0d expected %0d", first_hs_cyc - load_cyc, SETTLE + 1); end
    n_cmp++; if (out_ch_idx !== 8'd1) begin n_bad++; $display("FAIL ignore_idx: got %0d expected 1", out_ch_idx); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_random_stall();
    test_cfg_error();
    test_reset_midstream();
    test_ignored_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
